// File: rtl/apb_master_port.sv
// apb_master_port: core-side APB master for one interconnect master port.
// Turns a single-outstanding load/store request into an APB SETUP/ACCESS
// sequence, inserts a one-cycle PSELx-low gap after every transfer, and
// aborts the ACCESS phase with an error if PREADY never arrives.
//
// state  | meaning
// IDLE   | waiting for a core request, req_ready = 1
// SETUP  | PSELx = 1, PENABLE = 0, address/data/write driven
// ACCESS | PSELx = 1, PENABLE = 1, waiting for PREADY or timeout
// GAP    | PSELx = 0, rsp_valid pulse, wait counter cleared
module apb_master_port #(
  parameter int BUS_WIDTH  = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [BUS_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [BUS_WIDTH-1:0]  M_PADDR,
  output logic                  M_PWRITE,
  output logic                  M_PSELx,
  output logic                  M_PENABLE,
  output logic [DATA_WIDTH-1:0] M_PWDATA,
  input  logic [DATA_WIDTH-1:0] M_PRDATA,
  input  logic                  M_PREADY
);

  // TIMEOUT = 0 still needs a legal (1-bit) counter even though it is never compared
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Transfer sequencer: all bus and response outputs are registered here.
  // A wait cycle that would bring the counter up to TIMEOUT aborts instead,
  // unless PREADY is sampled high in that same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      M_PADDR   <= '0;
      M_PWRITE  <= 1'b0;
      M_PSELx   <= 1'b0;
      M_PENABLE <= 1'b0;
      M_PWDATA  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            M_PADDR  <= req_addr;
            M_PWDATA <= req_wdata;
            M_PWRITE <= req_write;
            M_PSELx  <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          M_PENABLE <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (M_PREADY) begin
            rsp_rdata <= M_PWRITE ? '0 : M_PRDATA;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            M_PSELx   <= 1'b0;
            M_PENABLE <= 1'b0;
            state     <= GAP;
          end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            M_PSELx   <= 1'b0;
            M_PENABLE <= 1'b0;
            state     <= GAP;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        GAP: begin
          wait_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_master_port.md
Name: apb_master_port

Overview:
- Core-side APB master that sits directly upstream of the APB interconnect. One instance per core.
- Converts a single-outstanding load/store request from the core memory stage into a compliant APB SETUP/ACCESS sequence on one master port of the interconnect, and returns read data or error to the core.
- Holds PSELx low for at least one cycle between transfers. The interconnect uses the falling PSELx as its end-of-transfer and arbitration-rotate event.
- Includes a wait-state timeout so a missing or unmapped slave cannot hang the core.

Parameters:
- BUS_WIDTH, 16, address width.
- DATA_WIDTH, 16, data width.
- TIMEOUT, 255, maximum ACCESS-phase cycles without PREADY before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  1  core requests a transfer.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  BUS_WIDTH  transfer address.
- req_wdata  in  DATA_WIDTH  store data.
- req_ready  out  1  request accepted this cycle when req_valid & req_ready.
- rsp_valid  out  1  one-cycle pulse: transfer complete.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid.
- rsp_err  out  1  timeout abort, valid with rsp_valid.
- busy  out  1  transfer in flight (state != IDLE).
- M_PADDR  out  BUS_WIDTH  APB address.
- M_PWRITE  out  1  APB write.
- M_PSELx  out  1  APB select for this master port.
- M_PENABLE  out  1  APB enable.
- M_PWDATA  out  DATA_WIDTH  APB write data.
- M_PRDATA  in  DATA_WIDTH  APB read data.
- M_PREADY  in  1  APB ready, already demuxed to this port by the interconnect.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; wait counter = 0.
  - All outputs 0, except req_ready, which is 1 once IDLE.
  - Reset mid-transfer drops PSELx/PENABLE immediately. No rsp_valid is produced for the aborted transfer.
- All outputs are registered except req_ready and busy, which decode state.
- States:
  - IDLE: req_ready = 1.
    - On req_valid: latch addr, wdata, write into M_PADDR, M_PWDATA, M_PWRITE; go to SETUP.
  - SETUP: PSELx = 1, PENABLE = 0; always go to ACCESS next cycle.
  - ACCESS: PSELx = 1, PENABLE = 1.
    - M_PREADY sampled 1: capture M_PRDATA into rsp_rdata (writes capture 0); rsp_err = 0; go to GAP.
    - M_PREADY sampled 0: increment wait counter.
    - Counter reaches TIMEOUT (TIMEOUT != 0): rsp_rdata = 0, rsp_err = 1, go to GAP.
    - PREADY arriving in the same cycle the counter hits TIMEOUT wins: normal completion, no error.
  - GAP: PSELx = 0, PENABLE = 0; rsp_valid = 1 for exactly this cycle; counter cleared; next state IDLE.
- Address, data and write signals:
  - M_PADDR, M_PWDATA and M_PWRITE are stable from SETUP through ACCESS.
  - They hold their last value in IDLE/GAP; they are not cleared.
- req_ready is 0 in SETUP/ACCESS/GAP. A req_valid asserted then is not accepted; the core must hold it until IDLE.
- Timing:
  - Minimum transfer with zero wait states: accept edge, SETUP, ACCESS, GAP = rsp_valid 3 cycles after the accept edge.
  - Back-to-back spacing is at least 4 cycles; PSELx is low for at least 1 cycle between transfers.
- rsp_rdata holds its value until the next completion.
- Wait counter:
  - Width is clog2(TIMEOUT+1).
  - Saturates; it never wraps.
  - It is only compared when TIMEOUT != 0.
- PENABLE must never be 1 while PSELx is 0.

Test Plan:
- Zero-wait read:
  - Stimulus: req addr 0x0010, slave PREADY = 1 in ACCESS with PRDATA 0xBEEF.
  - Required: PSEL high 2 cycles, PENABLE high 1 cycle; rsp_valid pulse 3 cycles after accept with rsp_rdata = 0xBEEF, rsp_err = 0.
- Wait-state write:
  - Stimulus: req write addr 0x0020, wdata 0x1234; PREADY held low 5 ACCESS cycles.
  - Required: PADDR/PWDATA stable throughout; rsp_valid 8 cycles after accept; rsp_rdata = 0.
- Back-to-back requests:
  - Stimulus: req_valid held high for 2 requests.
  - Required: second accept exactly 4 cycles after the first; PSELx 0 for 1 cycle between; req_ready = 0 in SETUP/ACCESS/GAP.
- Timeout:
  - Stimulus: TIMEOUT = 4, PREADY never asserted.
  - Required: abort after 4 ACCESS wait cycles; rsp_err = 1, rsp_rdata = 0; state returns to IDLE.
  - Repeat with PREADY asserted on the 4th cycle: required rsp_err = 0.
- Async reset mid-ACCESS:
  - Stimulus: assert reset low between clock edges.
  - Required: PSELx/PENABLE fall without waiting for a clock edge; no rsp_valid; after release, a new request completes normally.
- TIMEOUT = 0:
  - Stimulus: PREADY low for 300 cycles, then high.
  - Required: no abort; normal completion with rsp_err = 0.
